mmio_host_seq: RTL
==================

MMIO_HOST_SEQ -- requirements
Module: mmio_host_seq

Interface
REQ-001 Parameter: TIMEOUT, default 1000, maximum STATUS poll reads before abort (16-bit counter).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cmd_valid  in  1  host request to run one fuzzy computation.
REQ-006 cmd_ready  out  1  request accepted when cmd_valid && cmd_ready.
REQ-007 cmd_T  in  8  temperature value for register 0x02.
REQ-008 cmd_dT  in  8  manual dT for register 0x03, used only when cmd_dt_mode=0.
REQ-009 cmd_reg_mode, cmd_dt_mode  in  1 each  CTRL mode bits.
REQ-010 init_req  in  1  single-cycle request to issue an estimator init.
REQ-011 cs, rd, wr  out  1 each  MMIO strobes to the register block.
REQ-012 addr, wdata  out  8 each  MMIO address and write data.
REQ-013 rdata  in  8  MMIO read data, combinational from the register block, same cycle.
REQ-014 resp_valid  out  1  result available.
REQ-015 resp_ready  in  1  host consumes the result.
REQ-016 resp_G, resp_dT  out  8 each  read-back of G_out (0x04) and dT (0x03).
REQ-017 resp_timeout  out  1  poll limit reached; resp_G and resp_dT are 0.

Function
REQ-018 Bus access rules: every access is exactly one cycle with cs=1 and exactly one of rd/wr=1. Each access is followed by one idle cycle with cs=rd=wr=0 and addr=wdata=0.
REQ-019 Read sampling: rdata is captured at the rising edge ending the read cycle.
REQ-020 CTRL write format (addr 0x01): wdata={4'b0, init, dt_mode, reg_mode, start}.
REQ-021 States: IDLE, WR_CTRL, WR_T, WR_DT, WR_START, POLL, RD_G, RD_DT, RESP, INIT.
REQ-022 IDLE: cmd_ready=1 only in IDLE with init_req=0.
  - On accept, latch cmd_T, cmd_dT and both mode bits into mode_q/data registers, then go to WR_CTRL.
REQ-023 WR_CTRL writes 0x01 with start=0, init=0 and the latched modes; then go to WR_T.
REQ-024 WR_T writes 0x02=T; then go to WR_DT if dt_mode=0, else to WR_START.
REQ-025 WR_DT writes 0x03=dT; then go to WR_START.
REQ-026 WR_START writes 0x01 with start=1 and the same modes.
  - Clear the poll counter, then go to POLL.
  - The start write is never adjacent to another start=1 write, so the responder edge detect always fires.
REQ-027 POLL reads 0x00.
  - If rdata[1]=1 (valid) and rdata[0]=0 (busy), go to RD_G.
  - Otherwise increment the counter; when the counter reaches TIMEOUT, set timeout and go to RESP.
  - Otherwise repeat the read after the idle cycle.
REQ-028 RD_G reads 0x04 into resp_G, then RD_DT reads 0x03 into resp_dT; then go to RESP.
REQ-029 RESP: resp_valid=1 and all resp_* held stable until resp_ready=1; that cycle go to IDLE and drop resp_valid.
REQ-030 Response during RESP: resp_ready may already be high on RESP entry (handoff in one cycle). cmd_valid is ignored until IDLE.
REQ-031 INIT: init_req in IDLE wins over a simultaneous cmd_valid (cmd_ready=0 that cycle).
  - Write 0x01 with init=1, start=0 and the current mode_q; then go to IDLE.
  - No response is generated.
REQ-032 init_req outside IDLE is ignored (not queued).
REQ-033 Minimum latency, dt_mode=1, valid on the first poll: accept edge at cycle 0, accesses at cycles 1, 3, 5, 7, 9, 11, and resp_valid high from cycle 13.
REQ-034 Latency with dt_mode=0: two cycles longer.
REQ-035 Latency per failed poll: two cycles longer.
REQ-036 Poll counter: saturating 16-bit; TIMEOUT=0 is treated as 1.

Reset
REQ-037 rst=1 at a rising edge, including mid-sequence, forces the next cycle to:
  - state IDLE; cs=rd=wr=0; addr=wdata=0;
  - resp_valid=0, resp_G=0, resp_dT=0, resp_timeout=0;
  - poll counter 0, cmd_ready=1 once rst=0;
  - mode_q reg_mode=0, dt_mode=1 (matching the register block reset).
REQ-038 An aborted access is not retried after reset.

Verification
REQ-039 Command, auto dT: T=0x55, dt_mode=1, reg_mode=0; the model returns STATUS=0x02 on the first poll, G=0x7A, dT_mon=0x10.
  - Writes 0x01=0x04, 0x02=0x55, 0x01=0x05, then reads 0x00, 0x04, 0x03.
  - resp_G=0x7A, resp_dT=0x10, resp_timeout=0, resp_valid at cycle 13.
REQ-040 Command, manual dT: dt_mode=0, dT=0x20.
  - Write 0x03=0x20 appears between the T write and the start write (start wdata=0x01).
  - resp_valid at cycle 15.
REQ-041 Busy polling: model returns STATUS=0x01 three times, then 0x02.
  - Exactly 4 poll reads, and resp_valid delayed by 6 cycles versus REQ-039.
REQ-042 Timeout: TIMEOUT=5, STATUS stuck at 0x01.
  - Exactly 5 poll reads, then resp_timeout=1 with resp_G=resp_dT=0 and no reads of 0x04 or 0x03.
REQ-043 Init collision: init_req and cmd_valid in the same IDLE cycle.
  - cmd_ready=0; a single write 0x01=0x0C (init=1 with default modes dt_mode=1, reg_mode=0).
  - The command is accepted on the first IDLE cycle after it.
REQ-044 Reset and backpressure:
  - rst asserted during POLL: bus idle next cycle, resp_valid=0.
  - Separately, resp_ready held 0 for 10 cycles: resp_* stable and no bus activity throughout.

Source files
------------

// File: rtl/mmio_host_seq.sv
// Sequences one fuzzy computation over the MMIO register bus: CTRL/T/dT writes, start, STATUS poll, result read-back.
// Each access is one strobe cycle followed by one idle cycle; the result is held in RESP until resp_ready.
module mmio_host_seq #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_T,
  input  logic [7:0] cmd_dT,
  input  logic       cmd_reg_mode,
  input  logic       cmd_dt_mode,
  input  logic       init_req,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_G,
  output logic [7:0] resp_dT,
  output logic       resp_timeout
);

  localparam logic [7:0] A_STATUS = 8'h00;
  localparam logic [7:0] A_CTRL   = 8'h01;
  localparam logic [7:0] A_T      = 8'h02;
  localparam logic [7:0] A_DT     = 8'h03;
  localparam logic [7:0] A_G      = 8'h04;

  localparam logic [15:0] LIMIT = (TIMEOUT < 1)     ? 16'd1 :
                                  (TIMEOUT > 65535) ? 16'hFFFF : 16'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CTRL, S_WR_T, S_WR_DT, S_WR_START,
    S_POLL, S_RD_G, S_RD_DT, S_RESP, S_INIT
  } state_t;

  typedef struct packed {
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } bus_t;

  localparam bus_t BUS_IDLE = '0;

  function automatic bus_t bus_wr(input logic [7:0] a, input logic [7:0] d);
    bus_t b;
    b.cs    = 1'b1;
    b.rd    = 1'b0;
    b.wr    = 1'b1;
    b.addr  = a;
    b.wdata = d;
    return b;
  endfunction

  function automatic bus_t bus_rd(input logic [7:0] a);
    bus_t b;
    b.cs    = 1'b1;
    b.rd    = 1'b1;
    b.wr    = 1'b0;
    b.addr  = a;
    b.wdata = 8'h00;
    return b;
  endfunction

  function automatic logic [7:0] ctrl(input logic init, input logic dtm,
                                     input logic rgm, input logic start);
    return {4'b0000, init, dtm, rgm, start};
  endfunction

  state_t      state_q;
  logic        gap_q;
  bus_t        bus_q;
  logic        reg_mode_q, dt_mode_q;
  logic [7:0]  t_q, dt_q;
  logic [15:0] cnt_q, cnt_d;
  logic        resp_valid_q, resp_to_q;
  logic [7:0]  resp_g_q, resp_dt_q;

  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  assign cmd_ready    = (state_q == S_IDLE) && !init_req;
  assign cs           = bus_q.cs;
  assign rd           = bus_q.rd;
  assign wr           = bus_q.wr;
  assign addr         = bus_q.addr;
  assign wdata        = bus_q.wdata;
  assign resp_valid   = resp_valid_q;
  assign resp_G       = resp_g_q;
  assign resp_dT      = resp_dt_q;
  assign resp_timeout = resp_to_q;

  // Access states enter with gap_q=1 (the idle cycle after the previous access)
  // and launch their own strobe at the end of that gap; the strobe cycle has gap_q=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gap_q        <= 1'b0;
      bus_q        <= BUS_IDLE;
      reg_mode_q   <= 1'b0;
      dt_mode_q    <= 1'b1;
      t_q          <= 8'h00;
      dt_q         <= 8'h00;
      cnt_q        <= 16'h0000;
      resp_valid_q <= 1'b0;
      resp_to_q    <= 1'b0;
      resp_g_q     <= 8'h00;
      resp_dt_q    <= 8'h00;
    end else begin
      bus_q <= BUS_IDLE;
      case (state_q)
        S_IDLE: begin
          gap_q <= 1'b0;
          if (init_req) begin
            state_q <= S_INIT;
            bus_q   <= bus_wr(A_CTRL, ctrl(1'b1, dt_mode_q, reg_mode_q, 1'b0));
          end else if (cmd_valid) begin
            state_q    <= S_WR_CTRL;
            t_q        <= cmd_T;
            dt_q       <= cmd_dT;
            reg_mode_q <= cmd_reg_mode;
            dt_mode_q  <= cmd_dt_mode;
            resp_to_q  <= 1'b0;
            resp_g_q   <= 8'h00;
            resp_dt_q  <= 8'h00;
            bus_q      <= bus_wr(A_CTRL, ctrl(1'b0, cmd_dt_mode, cmd_reg_mode, 1'b0));
          end
        end
        S_WR_CTRL: begin
          gap_q   <= 1'b1;
          state_q <= S_WR_T;
        end
        S_WR_T: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            bus_q <= bus_wr(A_T, t_q);
          end else begin
            gap_q   <= 1'b1;
            state_q <= dt_mode_q ? S_WR_START : S_WR_DT;
          end
        end
        S_WR_DT: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            bus_q <= bus_wr(A_DT, dt_q);
          end else begin
            gap_q   <= 1'b1;
            state_q <= S_WR_START;
          end
        end
        S_WR_START: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            cnt_q <= 16'h0000;
            bus_q <= bus_wr(A_CTRL, ctrl(1'b0, dt_mode_q, reg_mode_q, 1'b1));
          end else begin
            gap_q   <= 1'b1;
            state_q <= S_POLL;
          end
        end
        S_POLL: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            bus_q <= bus_rd(A_STATUS);
          end else begin
            gap_q <= 1'b1;
            if (rdata[1] && !rdata[0]) begin
              state_q <= S_RD_G;
            end else begin
              cnt_q <= cnt_d;
              if (cnt_d >= LIMIT) begin
                resp_to_q <= 1'b1;
                state_q   <= S_RESP;
              end
            end
          end
        end
        S_RD_G: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            bus_q <= bus_rd(A_G);
          end else begin
            gap_q    <= 1'b1;
            resp_g_q <= rdata;
            state_q  <= S_RD_DT;
          end
        end
        S_RD_DT: begin
          if (gap_q) begin
            gap_q <= 1'b0;
            bus_q <= bus_rd(A_DT);
          end else begin
            gap_q     <= 1'b1;
            resp_dt_q <= rdata;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          if (gap_q) begin
            gap_q        <= 1'b0;
            resp_valid_q <= 1'b1;
          end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_INIT: begin
          if (gap_q) begin
            gap_q   <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= 1'b1;
          end
        end
        default: begin
          gap_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
